// File: rtl/pcm2pdm_modulator.sv
// PCM sample stream to 1-bit PDM: divided PDM clock, one-entry sample buffer, sigma-delta modulator.
// Define PCM2PDM_SECOND_ORDER_EN for a second-order loop; the default build is first order.
module pcm2pdm_modulator #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [7:0]       clock_divisor_i,
    input  logic [7:0]       interpolation_factor_i,
    input  logic [WIDTH-1:0] pcm_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             pdm_clk_o,
    output logic             pdm_o,
    output logic             underrun_o
);
    localparam int A1W = WIDTH + 2;
    localparam logic [A1W-1:0] A1_MAX = {1'b0, {(A1W-1){1'b1}}};
    localparam logic [A1W-1:0] A1_MIN = {1'b1, {(A1W-1){1'b0}}};

    logic [7:0]       div_cnt_reg;
    logic [7:0]       bit_cnt_reg;
    logic             pdm_clk_reg;
    logic             pdm_reg;
    logic             underrun_reg;
    logic             full_reg;
    logic [WIDTH-1:0] cur_reg;
    logic [WIDTH-1:0] buf_reg;
    logic [A1W-1:0]   acc1_reg;
    logic [A1W-1:0]   acc1_next;
    logic [A1W:0]     sum1;
    logic [WIDTH:0]   fb;
    logic             pdm_next;

    logic div_hit;
    logic bit_tick;
    logic wrap_tick;
    logic load;

    // ">=" so a divisor/factor lowered below the running count still wraps at once
    assign div_hit   = div_cnt_reg >= clock_divisor_i;
    assign bit_tick  = enable_i & div_hit & pdm_clk_reg;
    assign wrap_tick = bit_tick & (bit_cnt_reg >= interpolation_factor_i);
    assign ready_o   = enable_i & ~full_reg & ~rst_i;
    assign load      = valid_i & ready_o;

    assign fb = pdm_reg ? {2'b01, {(WIDTH-1){1'b0}}} : {2'b11, {(WIDTH-1){1'b0}}};

    always_comb begin
        sum1 = {acc1_reg[A1W-1], acc1_reg} + {{3{cur_reg[WIDTH-1]}}, cur_reg} - {{2{fb[WIDTH]}}, fb};
        if (sum1[A1W] != sum1[A1W-1])
            acc1_next = sum1[A1W] ? A1_MIN : A1_MAX;
        else
            acc1_next = sum1[A1W-1:0];
    end

`ifdef PCM2PDM_SECOND_ORDER_EN
    localparam int A2W = WIDTH + 4;
    localparam logic [A2W-1:0] A2_MAX = {1'b0, {(A2W-1){1'b1}}};
    localparam logic [A2W-1:0] A2_MIN = {1'b1, {(A2W-1){1'b0}}};

    logic [A2W-1:0] acc2_reg;
    logic [A2W-1:0] acc2_next;
    logic [A2W:0]   sum2;

    always_comb begin
        sum2 = {acc2_reg[A2W-1], acc2_reg} + {{3{acc1_next[A1W-1]}}, acc1_next} - {{4{fb[WIDTH]}}, fb};
        if (sum2[A2W] != sum2[A2W-1])
            acc2_next = sum2[A2W] ? A2_MIN : A2_MAX;
        else
            acc2_next = sum2[A2W-1:0];
        pdm_next = ~acc2_next[A2W-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            acc2_reg <= '0;
        else if (!enable_i)
            acc2_reg <= '0;
        else if (bit_tick)
            acc2_reg <= acc2_next;
    end
`else
    always_comb begin
        pdm_next = ~acc1_next[A1W-1];
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            pdm_clk_reg  <= 1'b0;
            pdm_reg      <= 1'b0;
            underrun_reg <= 1'b0;
            full_reg     <= 1'b0;
            cur_reg      <= '0;
            buf_reg      <= '0;
            acc1_reg     <= '0;
        end else if (!enable_i) begin
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            pdm_clk_reg  <= 1'b0;
            pdm_reg      <= 1'b0;
            underrun_reg <= 1'b0;
            full_reg     <= 1'b0;
            cur_reg      <= '0;
            buf_reg      <= '0;
            acc1_reg     <= '0;
        end else begin
            if (div_hit) begin
                div_cnt_reg <= '0;
                pdm_clk_reg <= ~pdm_clk_reg;
            end else begin
                div_cnt_reg <= div_cnt_reg + 8'd1;
            end

            underrun_reg <= wrap_tick & ~full_reg;

            if (bit_tick) begin
                bit_cnt_reg <= wrap_tick ? 8'd0 : bit_cnt_reg + 8'd1;
                acc1_reg    <= acc1_next;
                pdm_reg     <= pdm_next;
            end

            // The wrap sees the pre-load full flag, so a same-cycle load still underruns
            if (wrap_tick && full_reg) begin
                cur_reg  <= buf_reg;
                full_reg <= 1'b0;
            end
            if (load) begin
                buf_reg  <= pcm_i;
                full_reg <= 1'b1;
            end
        end
    end

    assign pdm_clk_o  = pdm_clk_reg;
    assign pdm_o      = pdm_reg;
    assign underrun_o = underrun_reg;

endmodule

// File: tb/tb_pcm2pdm_modulator.sv
// Directed bench for pcm2pdm_modulator: clock divisor, density, handshake, underrun, reset and enable.
module tb_pcm2pdm_modulator;
    localparam int WIDTH = 16;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             enable_i = 1'b1;
    logic [7:0]       clock_divisor_i = 8'd0;
    logic [7:0]       interpolation_factor_i = 8'd3;
    logic [WIDTH-1:0] pcm_i = '0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic             pdm_clk_o;
    logic             pdm_o;
    logic             underrun_o;

    always #5 clk_i = ~clk_i;

    pcm2pdm_modulator #(.WIDTH(WIDTH)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .enable_i              (enable_i),
        .clock_divisor_i       (clock_divisor_i),
        .interpolation_factor_i(interpolation_factor_i),
        .pcm_i                 (pcm_i),
        .valid_i               (valid_i),
        .ready_o               (ready_o),
        .pdm_clk_o             (pdm_clk_o),
        .pdm_o                 (pdm_o),
        .underrun_o            (underrun_o)
    );

    typedef struct {
        logic [7:0] divisor;
        int         exp_period;
        int         exp_high;
    } div_vec_t;

    typedef struct {
        logic [15:0] pcm;
        int          exp_ones;
        int          tol;
    } dens_vec_t;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    int ones_cnt = 0;
    int und_cnt = 0;
    int xfer_cnt = 0;
    int edge_viol = 0;
    logic prev_clk = 1'b0;
    logic prev_pdm = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end else begin
            $display("ok   %s: %0d in %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One clk_i cycle; outputs are sampled 1 time unit after the rising edge
    task automatic step();
        logic en_before;
        en_before = enable_i & ~rst_i;
        if (valid_i && ready_o) xfer_cnt++;
        @(posedge clk_i);
        #1;
        if (prev_clk && !pdm_clk_o) begin
            tick_cnt++;
            if (pdm_o) ones_cnt++;
        end
        if (underrun_o) und_cnt++;
        if (en_before && (pdm_o != prev_pdm) && !(prev_clk && !pdm_clk_o)) edge_viol++;
        prev_clk = pdm_clk_o;
        prev_pdm = pdm_o;
    endtask

    task automatic wait_ticks(input int n, input string name);
        int target;
        int budget;
        int cyc;
        target = tick_cnt + n;
        budget = n * 2 * (int'(clock_divisor_i) + 1) + 64;
        cyc = 0;
        while (tick_cnt < target && cyc < budget) begin
            step();
            cyc++;
        end
        if (tick_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, got %0d bit ticks expected %0d", name, n - (target - tick_cnt), n);
        end
    endtask

    div_vec_t  div_tab[4];
    dens_vec_t dens_tab[4];

    initial begin
        int hi;
        int lo;
        int guard;
        int base;
        int n;

        div_tab[0] = '{8'd0, 2, 1};
        div_tab[1] = '{8'd1, 4, 2};
        div_tab[2] = '{8'd3, 8, 4};
        div_tab[3] = '{8'd6, 14, 7};

        dens_tab[0] = '{16'h0000, 512, 2};
        dens_tab[1] = '{16'h4000, 768, 2};
        dens_tab[2] = '{16'h8000, 0, 2};
        dens_tab[3] = '{16'hC000, 256, 2};

        // Reset holds everything low even with enable_i high
        step();
        step();
        chk("reset_ready", ready_o, 0);
        chk("reset_pdm_clk", pdm_clk_o, 0);
        chk("reset_pdm", pdm_o, 0);
        chk("reset_underrun", underrun_o, 0);
        rst_i = 1'b0;
        step();
        chk("ready_after_release", ready_o, 1);

        // Divisor table: measure high time and period of pdm_clk_o
        for (int i = 0; i < 4; i++) begin
            enable_i = 1'b0;
            step();
            clock_divisor_i = div_tab[i].divisor;
            interpolation_factor_i = 8'd3;
            pcm_i = '0;
            valid_i = 1'b1;
            enable_i = 1'b1;
            guard = 0;
            while (!pdm_clk_o && guard < 600) begin
                step();
                guard++;
            end
            hi = 1;
            step();
            while (pdm_clk_o && hi < 600) begin
                hi++;
                step();
            end
            lo = 1;
            step();
            while (!pdm_clk_o && lo < 600) begin
                lo++;
                step();
            end
            chk($sformatf("div%0d_high", div_tab[i].divisor), hi, div_tab[i].exp_high);
            chk($sformatf("div%0d_period", div_tab[i].divisor), hi + lo, div_tab[i].exp_period);
        end

        // Density table: ones over 1024 bits for a constant input
        for (int i = 0; i < 4; i++) begin
            enable_i = 1'b0;
            valid_i = 1'b0;
            step();
            clock_divisor_i = 8'd0;
            interpolation_factor_i = 8'd63;
            pcm_i = dens_tab[i].pcm;
            valid_i = 1'b1;
            enable_i = 1'b1;
            wait_ticks(192, "density_settle");
            ones_cnt = 0;
            wait_ticks(1024, "density_run");
            chk_range($sformatf("density_%04h", dens_tab[i].pcm), ones_cnt,
                      dens_tab[i].exp_ones - dens_tab[i].tol, dens_tab[i].exp_ones + dens_tab[i].tol);
        end

        // Handshake with factor 3: one transfer per wrap, then underruns once valid stops
        enable_i = 1'b0;
        valid_i = 1'b0;
        step();
        clock_divisor_i = 8'd0;
        interpolation_factor_i = 8'd3;
        pcm_i = 16'h1000;
        valid_i = 1'b1;
        enable_i = 1'b1;
        wait_ticks(8, "hs_settle");
        xfer_cnt = 0;
        und_cnt = 0;
        wait_ticks(40, "hs_streaming");
        chk("hs_transfers", xfer_cnt, 10);
        chk("hs_no_underrun", und_cnt, 0);
        valid_i = 1'b0;
        xfer_cnt = 0;
        und_cnt = 0;
        wait_ticks(40, "hs_starved");
        chk("hs_underrun_pulses", und_cnt, 10);
        chk("hs_starved_transfers", xfer_cnt, 0);

        // Load in the wrap cycle with an empty buffer
        wait_ticks(3, "sim_align");
        step();
        pcm_i = 16'h4000;
        valid_i = 1'b1;
        base = tick_cnt;
        step();
        valid_i = 1'b0;
        chk("sim_is_wrap_tick", tick_cnt - base, 1);
        chk("sim_underrun", underrun_o, 1);
        chk("sim_full_ready", ready_o, 0);
        und_cnt = 0;
        wait_ticks(3, "sim_hold");
        chk("sim_buffer_held", ready_o, 0);
        wait_ticks(1, "sim_consume");
        chk("sim_consumed_ready", ready_o, 1);
        chk("sim_consumed_no_underrun", underrun_o, 0);

        // Asynchronous reset with the buffer full
        pcm_i = 16'h1234;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        step();
        chk("pre_reset_full", ready_o, 0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_ready", ready_o, 0);
        chk("async_rst_pdm_clk", pdm_clk_o, 0);
        chk("async_rst_pdm", pdm_o, 0);
        chk("async_rst_underrun", underrun_o, 0);
        step();
        rst_i = 1'b0;
        step();
        chk("post_reset_buffer_empty", ready_o, 1);

        // Disable mid-sample, then first tick latency on re-enable
        clock_divisor_i = 8'd2;
        guard = 0;
        while (!(pdm_clk_o && pdm_o) && guard < 200) begin
            step();
            guard++;
        end
        chk("dis_found_high_state", pdm_clk_o & pdm_o, 1);
        enable_i = 1'b0;
        step();
        chk("dis_pdm_clk", pdm_clk_o, 0);
        chk("dis_pdm", pdm_o, 0);
        chk("dis_ready", ready_o, 0);
        enable_i = 1'b1;
        base = tick_cnt;
        n = 0;
        while (tick_cnt == base && n < 100) begin
            step();
            n++;
        end
        chk("reenable_first_tick", n, 6);

        chk("pdm_changes_on_fall_only", edge_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcm2pdm_modulator.md
PCM2PDM_MODULATOR -- requirements
Module: pcm2pdm_modulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the signed two's-complement PCM sample width.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port enable_i, input, 1 bit: run enable; low means synchronous clear of all state except configuration inputs.
REQ-005 The block SHALL have port clock_divisor_i, input, 8 bits: pdm_clk_o half-period minus one, in clk_i cycles.
REQ-006 The block SHALL have port interpolation_factor_i, input, 8 bits: PDM bits per PCM sample minus one.
REQ-007 The block SHALL have port pcm_i, input, WIDTH bits: signed PCM sample.
REQ-008 The block SHALL have port valid_i, input, 1 bit: pcm_i valid.
REQ-009 The block SHALL have port ready_o, output, 1 bit: the sample buffer can accept; a transfer occurs when valid_i & ready_o.
REQ-010 The block SHALL have port pdm_clk_o, output, 1 bit: PDM clock to the device.
REQ-011 The block SHALL have port pdm_o, output, 1 bit: PDM data, stable around the rising edge of pdm_clk_o.
REQ-012 The block SHALL have port underrun_o, output, 1 bit: one-cycle pulse when a sample is due but the buffer is empty.

Function
REQ-013 A divider counter SHALL count 0..clock_divisor_i while enable_i=1. On reaching clock_divisor_i it SHALL clear and toggle pdm_clk_o. Divisor 0 gives pdm_clk_o = clk_i/2.
REQ-014 The bit tick is the cycle in which pdm_clk_o toggles 1->0. The modulator, pdm_o and the bit counter SHALL update only on a bit tick.
REQ-015 A one-entry buffer (next sample plus full flag) SHALL load pcm_i on valid_i & ready_o.
REQ-016 ready_o SHALL equal enable_i & !full. It SHALL have no combinational path from valid_i.
REQ-017 The bit counter SHALL count bit ticks 0..interpolation_factor_i and then wrap to 0.
REQ-018 On the wrap tick with full=1, the current sample SHALL be loaded from the buffer and full SHALL be cleared.
REQ-019 On the wrap tick with full=0, the current sample SHALL be held and underrun_o SHALL pulse for 1 cycle.
REQ-020 If a load and a wrap tick occur in the same cycle with full=0:
- the wrap SHALL see the buffer empty and raise underrun;
- the new sample SHALL be stored and full SHALL become 1.
REQ-021 If a wrap tick consumes the buffer, ready_o SHALL rise on the next cycle.
REQ-022 The modulator SHALL use feedback fb = +2^(WIDTH-1) when the current pdm_o=1, and -2^(WIDTH-1) otherwise.
REQ-023 The first integrator SHALL update as acc1 <= acc1 + x - fb, where x is the sign-extended current sample. acc1 SHALL be WIDTH+2 bits signed and SHALL saturate at its limits, never wrap.
REQ-024 In first-order mode, pdm_o SHALL be set to (new acc1 >= 0) on each bit tick.
REQ-025 Changes to clock_divisor_i or interpolation_factor_i while enabled SHALL take effect at the next counter compare. No glitch shorter than one clk_i cycle SHALL appear on pdm_clk_o.
REQ-026 When enable_i goes low, the next edge SHALL clear all state: counters, accumulators, current sample, buffer, pdm_clk_o=0, pdm_o=0.
REQ-027 When enable_i goes high, the first bit tick SHALL occur 2*(clock_divisor_i+1) cycles later.

Reset
REQ-028 While rst_i=1, all outputs SHALL be held at 0: pdm_clk_o, pdm_o, underrun_o, ready_o.
REQ-029 While rst_i=1, all internal registers SHALL be held at 0: counters, accumulators, current sample, buffer, full.
REQ-030 Reset asserted mid-operation SHALL abort immediately and SHALL discard any buffered sample.

Configuration
REQ-031 With macro PCM2PDM_SECOND_ORDER_EN defined, a second integrator SHALL be added:
- acc2 <= acc2 + new acc1 - fb, WIDTH+4 bits signed, saturating;
- pdm_o SHALL be set to (new acc2 >= 0).
REQ-032 Without PCM2PDM_SECOND_ORDER_EN, acc2 SHALL not exist and the first-order behaviour of REQ-024 SHALL apply.

Verification
REQ-033 Reset and enable: assert rst_i mid-stream with a buffer full -> all outputs 0 in the same cycle. After release with enable_i=1 -> ready_o=1 on the next cycle.
REQ-034 Divisor: divisor=1 -> pdm_clk_o period 4 cycles, 50% duty. Divisor=0 -> period 2. pdm_o changes only on 1->0 edges.
REQ-035 Density: factor=63, constant pcm 0x0000 over 1024 bits -> ones count 512±2. Constant 0x4000 -> 768±2. Constant 0x8000 -> 0±2. Run in both macro settings.
REQ-036 Handshake: factor=3, valid_i held high -> exactly one transfer per 4 bit ticks and underrun_o never asserted. Stop valid_i -> underrun_o pulses once per 4 ticks.
REQ-037 Simultaneous load and wrap with an empty buffer -> underrun_o=1 and full=1 in the same cycle. The sample becomes current at the following wrap.
REQ-038 Disable mid-sample: drop enable_i -> next cycle pdm_clk_o=0, pdm_o=0, ready_o=0. Re-enable -> first tick at 2*(divisor+1) cycles.
